// File: rtl/mod2n1_sub_pipe.sv
// rtl/mod2n1_sub_pipe.sv - 3-stage handshaked modulo-(2^16-1) add/sub, end-around-carry prefix datapath.
// Define MOD2N1_NORM_ZERO_EN to fold the 0xFFFF zero encoding to 0x0000 at the output.
module mod2n1_sub_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int N = WIDTH;

  generate
    if (WIDTH != 16) begin : g_width_check
      $error("mod2n1_sub_pipe supports WIDTH == 16 only");
    end
  endgenerate

  logic             en;
  logic [WIDTH-1:0] bm;

  logic             v1;
  logic [WIDTH-1:0] s1_g, s1_p, s1_x;
  logic [TAG_W-1:0] s1_tag;

  logic             v2;
  logic [WIDTH-1:0] s2_r1, s2_q1, s2_x;
  logic [TAG_W-1:0] s2_tag;

  logic [WIDTH-1:0] r1, q1, r2, d, jg, carry, jsum, res;

  // The whole pipe moves as one: it only freezes when a held result is not taken.
  assign en       = !out_valid | out_ready;
  assign in_ready = en;
  assign bm       = in_op ? ~in_b : in_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else if (en) begin
      v1     <= in_valid;
      s1_g   <= in_a & bm;
      s1_p   <= in_a | bm;
      s1_x   <= in_a ^ bm;
      s1_tag <= in_tag;
    end
  end

  // 4-bit cyclic groups ending at each bit; indices wrap so bit 0 sees bits 15..13.
  generate
    for (genvar i = 0; i < N; i++) begin : g_lvl1
      localparam int I1 = (i + N - 1) % N;
      localparam int I2 = (i + N - 2) % N;
      localparam int I3 = (i + N - 3) % N;
      assign r1[i] = s1_g[i]
                   | (s1_p[i] & s1_g[I1])
                   | (s1_p[i] & s1_p[I1] & s1_g[I2])
                   | (s1_p[i] & s1_p[I1] & s1_p[I2] & s1_g[I3]);
      assign q1[i] = s1_p[i] & s1_p[I1] & s1_p[I2] & s1_p[I3];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
    end else if (en) begin
      v2     <= v1;
      s2_r1  <= r1;
      s2_q1  <= q1;
      s2_x   <= s1_x;
      s2_tag <= s1_tag;
    end
  end

  // Widen to 8-bit then full-ring groups; the carry into bit i is the ring group ending at i-1.
  generate
    for (genvar i = 0; i < N; i++) begin : g_lvl2
      localparam int I4 = (i + N - 4) % N;
      localparam int I8 = (i + N - 8) % N;
      localparam int IP = (i + N - 1) % N;
      assign r2[i]    = s2_r1[i] | (s2_q1[i] & s2_r1[I4]);
      assign d[i]     = s2_q1[i] & s2_q1[I4];
      assign jg[i]    = r2[i] | (d[i] & r2[I8]);
      assign carry[i] = jg[IP];
    end
  endgenerate

  assign jsum = s2_x ^ carry;

`ifdef MOD2N1_NORM_ZERO_EN
  assign res = (&jsum) ? '0 : jsum;
`else
  assign res = jsum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (en) begin
      out_valid  <= v2;
      out_result <= res;
      out_tag    <= s2_tag;
    end
  end

endmodule

// File: tb/tb_mod2n1_sub_pipe.sv
// tb/tb_mod2n1_sub_pipe.sv - directed and streaming checks for mod2n1_sub_pipe.
module tb_mod2n1_sub_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_op, out_valid, out_ready;
  logic [15:0] in_a, in_b, out_result;
  logic [3:0]  in_tag, out_tag;
  int          total = 0;
  int          bad = 0;

  mod2n1_sub_pipe #(.WIDTH(16), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] model(input logic op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] bm, m;
    logic [16:0] r;
    bm = op ? ~b : b;
    r  = {1'b0, a} + {1'b0, bm};
    m  = r[15:0] + {15'd0, r[16]};
`ifdef MOD2N1_NORM_ZERO_EN
    if (m == 16'hFFFF) m = 16'h0000;
`endif
    return m;
  endfunction

  task automatic run_one(input logic op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] tag, output logic [15:0] res,
                         output logic [3:0] rtag, output int lat);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_result; rtag = out_tag;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_op = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_result !== 16'h0) begin bad++; $display("FAIL reset_out_result got=%h want=0000", out_result); end
    total++; if (out_tag !== 4'h0) begin bad++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_add;
    logic [15:0] r; logic [3:0] t; int l;
    run_one(1'b0, 16'h8000, 16'h8000, 4'hA, r, t, l);
    total++; if (r !== 16'h0001) begin bad++; $display("FAIL add_result got=%h want=0001", r); end
    total++; if (t !== 4'hA) begin bad++; $display("FAIL add_tag got=%h want=a", t); end
    total++; if (l !== 3) begin bad++; $display("FAIL add_latency got=%0d want=3", l); end
  endtask

  task automatic test_sub;
    logic [15:0] r; logic [3:0] t; int l;
    run_one(1'b1, 16'h0005, 16'h0003, 4'h3, r, t, l);
    total++; if (r !== 16'h0002) begin bad++; $display("FAIL sub_pos got=%h want=0002", r); end
    total++; if (t !== 4'h3) begin bad++; $display("FAIL sub_pos_tag got=%h want=3", t); end
    run_one(1'b1, 16'h0003, 16'h0005, 4'h5, r, t, l);
    total++; if (r !== 16'hFFFD) begin bad++; $display("FAIL sub_neg got=%h want=fffd", r); end
    total++; if (l !== 3) begin bad++; $display("FAIL sub_latency got=%0d want=3", l); end
  endtask

  task automatic test_zero;
    logic [15:0] r, want; logic [3:0] t; int l;
`ifdef MOD2N1_NORM_ZERO_EN
    want = 16'h0000;
`else
    want = 16'hFFFF;
`endif
    run_one(1'b1, 16'h1234, 16'h1234, 4'h7, r, t, l);
    total++; if (r !== want) begin bad++; $display("FAIL zero_sub_self got=%h want=%h", r, want); end
    run_one(1'b0, 16'hFFFF, 16'hFFFF, 4'h8, r, t, l);
    total++; if (r !== want) begin bad++; $display("FAIL zero_add_ones got=%h want=%h", r, want); end
    run_one(1'b0, 16'hFFFF, 16'h0001, 4'h9, r, t, l);
    total++; if (r !== 16'h0001) begin bad++; $display("FAIL wrap_add got=%h want=0001", r); end
  endtask

  task automatic test_back_to_back;
    logic [19:0] exp_q[$];
    int got = 0;
    logic saw_block = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic acc; int tries;
          tries = 0;
          in_valid = 1'b1; in_op = i[0]; in_a = 16'h1111 * i[15:0] + 16'h0123;
          in_b = 16'h0F0F + i[15:0]; in_tag = i[3:0];
          do begin
            @(negedge clk);
            acc = in_ready;
            if (acc) exp_q.push_back({in_tag, model(in_op, in_a, in_b)});
            @(posedge clk); #1;
            tries++;
          end while (!acc && tries < 100);
        end
        in_valid = 1'b0;
      end
      begin
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        logic [15:0] hr; logic [3:0] ht; logic hold; logic [19:0] e; int cyc;
        hold = 1'b0; cyc = 0;
        while (got < 8 && cyc < 200) begin
          @(negedge clk);
          cyc++;
          if (hold) begin
            total++;
            if (out_valid !== 1'b1 || out_result !== hr || out_tag !== ht) begin
              bad++; $display("FAIL stall_hold got=%b/%h/%h want=1/%h/%h", out_valid, out_result, out_tag, hr, ht);
            end
          end
          if (out_valid && !out_ready) begin
            saw_block = 1'b1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
            hold = 1'b1; hr = out_result; ht = out_tag;
          end else begin
            hold = 1'b0;
          end
          if (out_valid && out_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hxxxxx;
            total++;
            if ({out_tag, out_result} !== e) begin
              bad++; $display("FAIL b2b_item%0d got=%h/%h want=%h/%h", got, out_tag, out_result, e[19:16], e[15:0]);
            end
            got++;
          end
        end
      end
    join
    total++; if (got !== 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", got); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL b2b_leftover got=%0d want=0", exp_q.size()); end
    total++; if (saw_block !== 1'b1) begin bad++; $display("FAIL b2b_stall_seen got=%b want=1", saw_block); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] r; logic [3:0] t; int l; int seen;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_op = 1'b0; in_a = 16'h0100 + i[15:0]; in_b = 16'h0001; in_tag = 4'hC + i[3:0];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL midrst_full got=%b want=1", out_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midrst_ghost got=%0d want=0", seen); end
    run_one(1'b1, 16'h00F0, 16'h000F, 4'h6, r, t, l);
    total++; if (r !== 16'h00E1 || t !== 4'h6) begin bad++; $display("FAIL midrst_fresh got=%h/%h want=00e1/6", r, t); end
    total++; if (l !== 3) begin bad++; $display("FAIL midrst_latency got=%0d want=3", l); end
  endtask

  task automatic test_random;
    logic [19:0] exp_q[$];
    int sent = 0;
    int got = 0;
    localparam int NOPS = 10000;
    fork
      begin
        int cyc; cyc = 0;
        while (sent < NOPS && cyc < 60000) begin
          in_valid  = ($urandom_range(0, 3) != 0);
          in_op     = $urandom_range(0, 1);
          in_a      = $urandom;
          in_b      = ($urandom_range(0, 7) == 0) ? in_a : 16'($urandom);
          in_tag    = $urandom;
          out_ready = $urandom_range(0, 1);
          @(negedge clk);
          if (in_valid && in_ready) begin
            exp_q.push_back({in_tag, model(in_op, in_a, in_b)});
            sent++;
          end
          @(posedge clk); #1;
          cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
      end
      begin
        logic [19:0] e; int cyc; cyc = 0;
        while (got < NOPS && cyc < 70000) begin
          @(negedge clk);
          cyc++;
          if (out_valid && out_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hxxxxx;
            total++;
            if ({out_tag, out_result} !== e) begin
              bad++; $display("FAIL rand_item%0d got=%h/%h want=%h/%h", got, out_tag, out_result, e[19:16], e[15:0]);
            end
            got++;
          end
        end
      end
    join
    total++; if (got !== NOPS) begin bad++; $display("FAIL rand_count got=%0d want=%0d", got, NOPS); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_zero;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
